// File: rtl/freq_sweep_pkg.sv
// Shared types and defaults for the frequency sweep sequencer.
package freq_sweep_pkg;

  localparam int unsigned CODE_W_DFLT  = 8;
  localparam int unsigned DWELL_W_DFLT = 16;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DWELL     = 2'd1,
    ST_WAIT_EDGE = 2'd2,
    ST_DONE      = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/freq_sweep_ctrl_if.sv
// Control/status bundle between the register logic and the sweep sequencer.
interface freq_sweep_ctrl_if
  import freq_sweep_pkg::*;
#(
  parameter int unsigned CODE_W  = CODE_W_DFLT,
  parameter int unsigned DWELL_W = DWELL_W_DFLT
) ();

  logic               start;
  logic               abort;
  logic [CODE_W-1:0]  start_code;
  logic [CODE_W-1:0]  stop_code;
  logic [CODE_W-1:0]  step_size;
  logic [DWELL_W-1:0] dwell;
  logic [CODE_W-1:0]  freq_param;
  logic               busy;
  logic               done;
  logic               step_strobe;

  modport master (
    output start, abort, start_code, stop_code, step_size, dwell,
    input  freq_param, busy, done, step_strobe
  );

  modport slave (
    input  start, abort, start_code, stop_code, step_size, dwell,
    output freq_param, busy, done, step_strobe
  );

endinterface

// File: rtl/pll_edge_det.sv
// Rising-edge detector for the PLL output, sampled in the clk_in domain.
module pll_edge_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic pll_clk,
  output logic rise_c
);

  logic pll_clk_d_q;
  logic pll_clk_d_d;

  always_comb pll_clk_d_d = pll_clk;

  always_ff @(posedge clk_in) begin
    if (!rst_n) pll_clk_d_q <= 1'b0;
    else        pll_clk_d_q <= pll_clk_d_d;
  end

  assign rise_c = pll_clk & ~pll_clk_d_q;

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Steps the PLL frequency code from start_code to stop_code, changing it only on PLL rising edges.
// SWEEP_LOOP_EN: wrap back to start_code after stop_code and never finish.
module freq_sweep_ctrl
  import freq_sweep_pkg::*;
#(
  parameter int unsigned CODE_W  = CODE_W_DFLT,
  parameter int unsigned DWELL_W = DWELL_W_DFLT
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            pll_clk,
  freq_sweep_ctrl_if.slave sw
);

  sweep_state_t       state_q, state_d;
  logic [CODE_W-1:0]  start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [CODE_W-1:0]  next_q, next_d, freq_q, freq_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d, done_q, done_d, strobe_q, strobe_d;

  logic               rise_c, accept_c, last_c, at_stop_c;
  logic [CODE_W:0]    sum_c, diff_c;
  logic [CODE_W-1:0]  calc_c;

  pll_edge_det u_edge (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .pll_clk (pll_clk),
    .rise_c  (rise_c)
  );

  assign accept_c  = sw.start & ~sw.abort;
  assign last_c    = (cnt_q == '0);
  assign at_stop_c = (freq_q == stop_q);

  // Next code, computed one bit wider so it clamps at stop_code instead of wrapping
  always_comb begin
    sum_c  = {1'b0, freq_q} + {1'b0, step_q};
    diff_c = {1'b0, freq_q} - {1'b0, step_q};
    if (dir_q == DIR_UP) calc_c = (sum_c > {1'b0, stop_q}) ? stop_q : sum_c[CODE_W-1:0];
    else calc_c = (diff_c[CODE_W] || (diff_c[CODE_W-1:0] < stop_q)) ? stop_q : diff_c[CODE_W-1:0];
`ifdef SWEEP_LOOP_EN
    if (at_stop_c) calc_c = start_q;
`else
    if (at_stop_c) calc_c = stop_q;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      next_q   <= '0;
      freq_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      next_q   <= next_d;
      freq_q   <= freq_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept_c) state_d = ST_DWELL;
      ST_DWELL: begin
        if (sw.abort) state_d = ST_IDLE;
        else if (last_c) begin
`ifdef SWEEP_LOOP_EN
          state_d = ST_WAIT_EDGE;
`else
          state_d = at_stop_c ? ST_DONE : ST_WAIT_EDGE;
`endif
        end
      end
      ST_WAIT_EDGE: begin
        if (sw.abort)   state_d = ST_IDLE;
        else if (rise_c) state_d = ST_DWELL;
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; config is captured only on an accepted start
  always_comb begin
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    dir_d    = dir_q;
    next_d   = next_q;
    freq_d   = freq_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    busy_d   = (state_d == ST_DWELL) || (state_d == ST_WAIT_EDGE);
    done_d   = (state_d == ST_DONE);
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          start_d  = sw.start_code;
          stop_d   = sw.stop_code;
          step_d   = (sw.step_size == '0) ? CODE_W'(1) : sw.step_size;
          dwell_d  = (sw.dwell == '0) ? '0 : sw.dwell - DWELL_W'(1);
          cnt_d    = (sw.dwell == '0) ? '0 : sw.dwell - DWELL_W'(1);
          dir_d    = (sw.stop_code >= sw.start_code) ? DIR_UP : DIR_DOWN;
          freq_d   = sw.start_code;
          strobe_d = 1'b1;
        end
      end
      ST_DWELL: begin
        if (!sw.abort) begin
          if (last_c) next_d = calc_c;
          else        cnt_d  = cnt_q - DWELL_W'(1);
        end
      end
      ST_WAIT_EDGE: begin
        if (!sw.abort && rise_c) begin
          freq_d   = next_q;
          strobe_d = 1'b1;
          cnt_d    = dwell_q;
        end
      end
      default: ;
    endcase
  end

  assign sw.freq_param  = freq_q;
  assign sw.busy        = busy_q;
  assign sw.done        = done_q;
  assign sw.step_strobe = strobe_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl: directed and random sweeps against a code-list model.
module tb_freq_sweep_ctrl;
  import freq_sweep_pkg::*;

  localparam int unsigned CW = CODE_W_DFLT;
  localparam int unsigned DW = DWELL_W_DFLT;

  logic clk_in  = 1'b0;
  logic rst_n   = 1'b0;
  logic pll_clk = 1'b0;

  freq_sweep_ctrl_if #(.CODE_W(CW), .DWELL_W(DW)) sif ();

  freq_sweep_ctrl #(.CODE_W(CW), .DWELL_W(DW)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .pll_clk (pll_clk),
    .sw      (sif.slave)
  );

  always #5 clk_in = ~clk_in;

  // PLL output: synchronous to clk_in, toggles every pll_half cycles
  int pll_half = 3;
  int pll_cnt  = 0;
  always begin
    @(posedge clk_in);
    #1;
    if (pll_cnt >= pll_half - 1) begin
      pll_cnt = 0;
      pll_clk = ~pll_clk;
    end else begin
      pll_cnt++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic p_at0    = 1'b0;
  logic p_at1    = 1'b0;
  int   exp_q[$];
  int   obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; p_at0/p_at1 = pll_clk as seen by the last two posedges
  task automatic tick();
    logic p;
    p = pll_clk;
    @(negedge clk_in);
    cyc++;
    p_at1 = p_at0;
    p_at0 = p;
  endtask

  task automatic scramble();
    sif.start_code = CW'($urandom);
    sif.stop_code  = CW'($urandom);
    sif.step_size  = CW'($urandom);
    sif.dwell      = DW'($urandom_range(0, 9));
  endtask

  // Expected code sequence: start, then +/- step clamped at stop, ending at stop
  function automatic void model(input int s, input int e, input int st);
    int c;
    int stp;
    exp_q.delete();
    stp = (st == 0) ? 1 : st;
    c = s;
    exp_q.push_back(c);
    while (c != e) begin
      if (e >= s) c = (c + stp > e) ? e : c + stp;
      else        c = (c - stp < e) ? e : c - stp;
      exp_q.push_back(c);
    end
  endfunction

  task automatic apply_start(input int s, input int e, input int st, input int dw);
    sif.start_code = CW'(s);
    sif.stop_code  = CW'(e);
    sif.step_size  = CW'(st);
    sif.dwell      = DW'(dw);
    sif.start      = 1'b1;
    tick();
    sif.start = 1'b0;
    scramble();
  endtask

  task automatic run_sweep(input string tag, input int s, input int e, input int st, input int dw);
    int dwe, budget, last_sc, done_cyc, n_done, edge_bad, space_bad, n;
    logic done_busy;
    model(s, e, st);
    dwe = (dw == 0) ? 1 : dw;
    budget = exp_q.size() * (dwe + 2 * pll_half + 4) + 20;
    obs_q.delete();
    n_done = 0; edge_bad = 0; space_bad = 0; last_sc = 0; done_cyc = 0; done_busy = 1'b1;
    apply_start(s, e, st, dw);
    check({tag, "_busy_after_start"}, 32'(sif.busy), 32'd1);
    for (int k = 0; k < budget; k++) begin
      if (sif.step_strobe) begin
        if (obs_q.size() > 0) begin
          if (!(p_at1 == 1'b0 && p_at0 == 1'b1)) edge_bad++;
          if (cyc - last_sc < dwe + 1) space_bad++;
        end
        obs_q.push_back(int'(sif.freq_param));
        last_sc = cyc;
      end
      if (sif.done) begin
        n_done++;
        if (n_done == 1) begin
          done_cyc  = cyc;
          done_busy = sif.busy;
        end
      end
      if (n_done > 0 && cyc - done_cyc >= 4) break;
      sif.start = sif.busy && ($urandom_range(0, 5) == 0);
      if (sif.start) scramble();
      tick();
    end
    sif.start = 1'b0;
    check({tag, "_ncodes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_code"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_on_pll_rise"}, 32'(edge_bad), 32'd0);
    check({tag, "_dwell_spacing"}, 32'(space_bad), 32'd0);
    check({tag, "_done_count"}, 32'(n_done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(done_busy), 32'd0);
    check({tag, "_last_dwell"}, 32'(done_cyc - last_sc), 32'(dwe));
    check({tag, "_final_code"}, 32'(sif.freq_param), 32'(e));
    check({tag, "_idle_busy"}, 32'(sif.busy), 32'd0);
  endtask

  initial begin
    int found;
    int stray;
    int s, e, st, dw;
    sif.start = 1'b0; sif.abort = 1'b0;
    sif.start_code = '0; sif.stop_code = '0; sif.step_size = '0; sif.dwell = '0;

    rst_n = 1'b0;
    tick(); tick();
    check("rst_freq", 32'(sif.freq_param), 32'd0);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_strobe", 32'(sif.step_strobe), 32'd0);
    rst_n = 1'b1;
    tick();

    // start and abort together in IDLE: abort wins
    sif.start_code = 8'd50; sif.stop_code = 8'd60; sif.step_size = 8'd1; sif.dwell = 16'd2;
    sif.start = 1'b1; sif.abort = 1'b1;
    tick();
    sif.start = 1'b0; sif.abort = 1'b0;
    check("start_abort_busy", 32'(sif.busy), 32'd0);
    check("start_abort_strobe", 32'(sif.step_strobe), 32'd0);
    tick();
    check("start_abort_busy2", 32'(sif.busy), 32'd0);

`ifndef SWEEP_LOOP_EN
    pll_half = 3;
    run_sweep("up", 10, 40, 10, 5);
    run_sweep("down_clamp", 200, 5, 50, 4);
    run_sweep("equal", 7, 7, 0, 0);
    for (int r = 0; r < 8; r++) begin
      pll_half = $urandom_range(1, 3);
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      st = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
      dw = $urandom_range(0, 6);
      run_sweep("rand", s, e, st, dw);
    end
`else
    // continuous sweep: 1,2,3 repeating, never done
    pll_half = 2;
    dw = $urandom_range(0, 3);
    obs_q.delete();
    stray = 0;
    apply_start(1, 3, 1, dw);
    for (int k = 0; k < 200 && obs_q.size() < 9; k++) begin
      if (sif.step_strobe) obs_q.push_back(int'(sif.freq_param));
      if (sif.done) stray++;
      tick();
    end
    check("loop_ncodes", 32'(obs_q.size()), 32'd9);
    for (int i = 0; i < obs_q.size(); i++) check("loop_code", 32'(obs_q[i]), 32'((i % 3) + 1));
    check("loop_no_done", 32'(stray), 32'd0);
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    check("loop_abort_busy", 32'(sif.busy), 32'd0);
    tick();
`endif

    // abort mid-dwell at code 30
    pll_half = 3;
    found = 0;
    apply_start(10, 40, 10, 8);
    for (int k = 0; k < 200; k++) begin
      if (sif.step_strobe && sif.freq_param == 8'd30) begin
        found = 1;
        break;
      end
      tick();
    end
    check("abort_reach_30", 32'(found), 32'd1);
    tick();
    sif.start_code = 8'd99; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    check("ignored_start_code", 32'(sif.freq_param), 32'd30);
    sif.abort = 1'b1; sif.start = 1'b1;
    tick();
    sif.abort = 1'b0; sif.start = 1'b0;
    check("abort_busy", 32'(sif.busy), 32'd0);
    check("abort_freq", 32'(sif.freq_param), 32'd30);
    check("abort_done", 32'(sif.done), 32'd0);
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (sif.step_strobe || sif.done || sif.busy || sif.freq_param != 8'd30) stray++;
    end
    check("abort_quiet", 32'(stray), 32'd0);

    // reset in the middle of a sweep
    apply_start(100, 20, 7, 3);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_freq", 32'(sif.freq_param), 32'd0);
    check("midrst_busy", 32'(sif.busy), 32'd0);
    tick(); tick();
    check("midrst_idle", 32'(sif.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
